// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle multiply/divide unit in the execute stage.
// Sequences operand load, iteration stepping, fast-path results and result retirement.
module multicycle_ctrl #(
    parameter int unsigned MUL_LAT     = 3,
    parameter int unsigned DIV_ITERS64 = 64,
    parameter int unsigned DIV_ITERS32 = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flushDE,
    input  logic        stalllDE,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic        is_32instr,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        load,
    output logic        step_en,
    output logic [6:0]  iter,
    output logic        sel_div,
    output logic [1:0]  special,
    output logic        result_valid,
    output logic        doing
);

    localparam int unsigned IW = 7;
    localparam int unsigned SW = 2;

    localparam logic [IW-1:0] MUL_LAST   = IW'(MUL_LAT - 1);
    localparam logic [IW-1:0] DIV32_LAST = IW'(DIV_ITERS32 - 1);
    localparam logic [IW-1:0] DIV64_LAST = IW'(DIV_ITERS64 - 1);

    localparam logic [SW-1:0] SP_NONE = SW'(0);
    localparam logic [SW-1:0] SP_DIV0 = SW'(1);
    localparam logic [SW-1:0] SP_OVF  = SW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic            div_q, div_d;
    logic            is32_q, is32_d;
    logic [SW-1:0]   special_q, special_d;

    logic            accept_c;
    logic            div_zero_c;
    logic            div_ovf_c;
    logic [SW-1:0]   special_in_c;
    logic [IW-1:0]   iter_last_c;

    // Fast-path detection on the incoming operands; divide-by-zero wins over overflow.
    always_comb begin
        div_zero_c = is_32instr ? (b[31:0] == 32'd0) : (b == 64'd0);
        div_ovf_c  = ((op == 3'd4) || (op == 3'd6)) &&
                     (is_32instr ? ((b[31:0] == 32'hFFFF_FFFF) && (a[31:0] == 32'h8000_0000))
                                 : ((b == 64'hFFFF_FFFF_FFFF_FFFF) && (a == 64'h8000_0000_0000_0000)));
        if (op[2] && div_zero_c) begin
            special_in_c = SP_DIV0;
        end else if (div_ovf_c) begin
            special_in_c = SP_OVF;
        end else begin
            special_in_c = SP_NONE;
        end
    end

    // Last iteration index for the latched operation.
    always_comb begin
        if (!div_q) begin
            iter_last_c = MUL_LAST;
        end else if (is32_q) begin
            iter_last_c = DIV32_LAST;
        end else begin
            iter_last_c = DIV64_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            div_q     <= 1'b0;
            is32_q    <= 1'b0;
            special_q <= SP_NONE;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            div_q     <= div_d;
            is32_q    <= is32_d;
            special_q <= special_d;
        end
    end

    // Next-state and per-cycle strobes; flushDE beats both req and completion.
    always_comb begin
        state_d      = state_q;
        iter_d       = iter_q;
        div_d        = div_q;
        is32_d       = is32_q;
        special_d    = special_q;
        load         = 1'b0;
        step_en      = 1'b0;
        result_valid = 1'b0;
        accept_c     = (state_q == IDLE) && req && !flushDE;
        doing        = accept_c || (state_q == BUSY);

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    load      = 1'b1;
                    div_d     = op[2];
                    is32_d    = is_32instr;
                    special_d = special_in_c;
                    if (special_in_c != SP_NONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        iter_d  = '0;
                    end
                end
            end
            BUSY: begin
                if (flushDE) begin
                    state_d = IDLE;
                end else begin
                    step_en = 1'b1;
                    if (iter_q == iter_last_c) begin
                        state_d = DONE;
                    end else begin
                        iter_d = iter_q + IW'(1);
                    end
                end
            end
            DONE: begin
                // Return to IDLE only; a new accept needs a fresh IDLE cycle.
                if (flushDE) begin
                    state_d = IDLE;
                end else begin
                    result_valid = 1'b1;
                    if (!stalllDE) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign iter    = iter_q;
    assign sel_div = div_q;
    assign special = special_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl with default parameters.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flushDE;
    logic        stalllDE;
    logic        req;
    logic [2:0]  op;
    logic        is_32instr;
    logic [63:0] a;
    logic [63:0] b;
    logic        load;
    logic        step_en;
    logic [6:0]  iter;
    logic        sel_div;
    logic [1:0]  special;
    logic        result_valid;
    logic        doing;

    int tests = 0;
    int fails = 0;
    int nload;
    int nstep;
    int nrv;

    multicycle_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .flushDE      (flushDE),
        .stalllDE     (stalllDE),
        .req          (req),
        .op           (op),
        .is_32instr   (is_32instr),
        .a            (a),
        .b            (b),
        .load         (load),
        .step_en      (step_en),
        .iter         (iter),
        .sel_div      (sel_div),
        .special      (special),
        .result_valid (result_valid),
        .doing        (doing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change right after the falling edge; outputs are checked 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; flushDE = 1'b0; stalllDE = 1'b0; req = 1'b0;
        op = 3'd0; is_32instr = 1'b0; a = '0; b = '0;
        cyc(); cyc();
        reset = 1'b0;
        settle();
        chk("rst_load", 64'(load), 0);
        chk("rst_step", 64'(step_en), 0);
        chk("rst_iter", 64'(iter), 0);
        chk("rst_seldiv", 64'(sel_div), 0);
        chk("rst_special", 64'(special), 0);
        chk("rst_rv", 64'(result_valid), 0);
        chk("rst_doing", 64'(doing), 0);

        // MUL 3*5: load at 0, step 1..3, result at 4
        cyc(); req = 1'b1; op = 3'd0; is_32instr = 1'b0; a = 64'd3; b = 64'd5; settle();
        chk("mul_load0", 64'(load), 1);
        chk("mul_doing0", 64'(doing), 1);
        chk("mul_step0", 64'(step_en), 0);
        for (int c = 1; c <= 3; c++) begin
            cyc(); req = 1'b0; settle();
            chk("mul_step", 64'(step_en), 1);
            chk("mul_iter", 64'(iter), 64'(c - 1));
            chk("mul_doing", 64'(doing), 1);
            chk("mul_rv_busy", 64'(result_valid), 0);
        end
        cyc(); settle();
        chk("mul_rv4", 64'(result_valid), 1);
        chk("mul_doing4", 64'(doing), 0);
        chk("mul_step4", 64'(step_en), 0);
        chk("mul_seldiv", 64'(sel_div), 0);
        chk("mul_iter_hold", 64'(iter), 2);
        cyc(); settle();
        chk("mul_rv5", 64'(result_valid), 0);

        // DIVW by 0 on the low word
        cyc(); req = 1'b1; op = 3'd4; is_32instr = 1'b1; a = 64'd9; b = 64'h0000_0001_0000_0000; settle();
        chk("divw0_load", 64'(load), 1);
        cyc(); req = 1'b0; settle();
        chk("divw0_special", 64'(special), 1);
        chk("divw0_rv", 64'(result_valid), 1);
        chk("divw0_step", 64'(step_en), 0);
        chk("divw0_seldiv", 64'(sel_div), 1);
        cyc(); settle();
        chk("divw0_rv2", 64'(result_valid), 0);

        // DIV signed overflow
        cyc(); req = 1'b1; op = 3'd4; is_32instr = 1'b0;
        a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; settle();
        chk("ovf_load", 64'(load), 1);
        cyc(); req = 1'b0; settle();
        chk("ovf_special", 64'(special), 2);
        chk("ovf_rv", 64'(result_valid), 1);
        chk("ovf_step", 64'(step_en), 0);
        cyc(); settle();

        // DIVU with the same operands: 64 iterations
        cyc(); req = 1'b1; op = 3'd5; settle();
        chk("divu_load", 64'(load), 1);
        nstep = 0; nrv = 0;
        for (int c = 1; c <= 64; c++) begin
            cyc(); req = 1'b0; settle();
            if (step_en) nstep++;
            if (result_valid) nrv++;
            if (c == 1 || c == 64) chk("divu_iter", 64'(iter), 64'(c - 1));
        end
        chk("divu_nstep", 64'(nstep), 64);
        chk("divu_norv", 64'(nrv), 0);
        cyc(); settle();
        chk("divu_rv65", 64'(result_valid), 1);
        chk("divu_special", 64'(special), 0);
        chk("divu_iter_end", 64'(iter), 63);
        cyc(); settle();

        // flushDE beats req in IDLE
        cyc(); req = 1'b1; flushDE = 1'b1; op = 3'd0; settle();
        chk("flush_idle_load", 64'(load), 0);
        chk("flush_idle_doing", 64'(doing), 0);
        cyc(); req = 1'b0; flushDE = 1'b0; settle();
        chk("flush_idle_step", 64'(step_en), 0);

        // DIV flushed at iter 10, then a MUL accepted normally
        cyc(); req = 1'b1; op = 3'd4; is_32instr = 1'b0; a = 64'd100; b = 64'd7; settle();
        chk("fl_load", 64'(load), 1);
        for (int c = 1; c <= 10; c++) begin
            cyc(); req = 1'b0; settle();
        end
        cyc(); flushDE = 1'b1; settle();
        chk("fl_iter10", 64'(iter), 10);
        chk("fl_step", 64'(step_en), 0);
        chk("fl_rv", 64'(result_valid), 0);
        cyc(); flushDE = 1'b0; settle();
        chk("fl_after_doing", 64'(doing), 0);
        chk("fl_after_rv", 64'(result_valid), 0);
        chk("fl_after_step", 64'(step_en), 0);
        cyc(); req = 1'b1; op = 3'd0; a = 64'd2; b = 64'd2; settle();
        chk("fl_new_load", 64'(load), 1);
        for (int c = 1; c <= 3; c++) begin
            cyc(); req = 1'b0; settle();
        end
        cyc(); settle();
        chk("fl_new_rv", 64'(result_valid), 1);
        cyc(); settle();

        // REMW with 3 stall cycles at completion, req held until retire
        nload = 0; nrv = 0;
        cyc(); req = 1'b1; op = 3'd6; is_32instr = 1'b1; a = 64'd17; b = 64'd5; settle();
        if (load) nload++;
        for (int c = 1; c <= 32; c++) begin
            cyc(); settle();
            if (load) nload++;
            if (result_valid) nrv++;
        end
        chk("remw_no_early_rv", 64'(nrv), 0);
        for (int c = 33; c <= 36; c++) begin
            cyc(); stalllDE = (c <= 35); settle();
            if (load) nload++;
            chk("remw_rv_hold", 64'(result_valid), 1);
            chk("remw_doing", 64'(doing), 0);
        end
        cyc(); req = 1'b0; stalllDE = 1'b0; settle();
        chk("remw_rv_end", 64'(result_valid), 0);
        chk("remw_nload", 64'(nload), 1);

        // Reset during DIV at iter 20
        cyc(); req = 1'b1; op = 3'd4; is_32instr = 1'b0; a = 64'd1000; b = 64'd3; settle();
        for (int c = 1; c <= 20; c++) begin
            cyc(); req = 1'b0; settle();
        end
        cyc(); reset = 1'b1; settle();
        chk("rstb_iter20", 64'(iter), 20);
        cyc(); reset = 1'b0; settle();
        chk("rstb_load", 64'(load), 0);
        chk("rstb_step", 64'(step_en), 0);
        chk("rstb_iter", 64'(iter), 0);
        chk("rstb_seldiv", 64'(sel_div), 0);
        chk("rstb_special", 64'(special), 0);
        chk("rstb_rv", 64'(result_valid), 0);
        chk("rstb_doing", 64'(doing), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: MUL_LAT, default 3, number of BUSY cycles for any multiply op.
REQ-002 Parameters: DIV_ITERS64, default 64, BUSY cycles for a 64-bit divide/remainder.
REQ-003 Parameters: DIV_ITERS32, default 32, BUSY cycles for a 32-bit (word) divide/remainder.
REQ-004 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port: reset, input, 1, synchronous, active-high.
REQ-006 Port: flushDE, input, 1, kill the in-flight multicycle instruction.
REQ-007 Port: stalllDE, input, 1, downstream stall; the execute stage cannot retire this cycle.
REQ-008 Port: req, input, 1, the execute stage holds a valid instruction with aluop == ALU_MULTICYCLE.
REQ-009 Port: op, input, 3, RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-010 Port: is_32instr, input, 1, word-form instruction (W suffix).
REQ-011 Port: a, input, 64, forwarded operand A.
REQ-012 Port: b, input, 64, forwarded operand B.
REQ-013 Port: load, output, 1, datapath captures operands and op this cycle.
REQ-014 Port: step_en, output, 1, datapath performs one iteration this cycle.
REQ-015 Port: iter, output, 7, current iteration index.
REQ-016 Port: sel_div, output, 1, the latched op is divide/remainder (op[2]).
REQ-017 Port: special, output, 2, latched fast-path code: 0 none, 1 divide-by-zero, 2 signed overflow.
REQ-018 Port: result_valid, output, 1, the datapath result is final and may be consumed.
REQ-019 Port: doing, output, 1, the execute stage must stall.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-021 Accept condition: state == IDLE && req && !flushDE; on accept, load=1 and op, is_32instr and special SHALL latch.
REQ-022 special SHALL be 1 when op[2]=1 and the divisor is zero (b[31:0] if is_32instr, else b[63:0]).
REQ-023 special SHALL be 2 when op in {4,6}, the divisor is -1 and the dividend is the most-negative value, at the selected width.
REQ-024 The divide-by-zero check SHALL take priority over the overflow check.
REQ-025 On accept with special != 0, the next state SHALL be DONE; no BUSY cycles and step_en stays 0.
REQ-026 On any other accept, the next state SHALL be BUSY with iter=0.
REQ-027 In BUSY, step_en=1 and iter SHALL increment each cycle.
REQ-028 BUSY SHALL exit to DONE after iter reaches N-1, with N=MUL_LAT for multiplies, DIV_ITERS32 for word divides and DIV_ITERS64 otherwise.
REQ-029 Latency from the accept cycle t: result_valid SHALL be 1 at t+1 on the fast path, t+1+MUL_LAT for multiplies, t+1+N for divides.
REQ-030 In DONE, result_valid=1 and doing=0.
REQ-031 DONE SHALL remain DONE while stalllDE=1 and go to IDLE when stalllDE=0.
REQ-032 Leaving DONE SHALL not re-accept in that same cycle, so the same instruction is never launched twice.
REQ-033 doing SHALL equal (accept condition) | (state == BUSY).
REQ-034 stalllDE SHALL NOT pause iteration in BUSY.
REQ-035 flushDE=1 in any state SHALL force IDLE next cycle and suppress load, step_en and result_valid that cycle.
REQ-036 flushDE SHALL override req and completion when they occur in the same cycle.
REQ-037 req deasserting during BUSY SHALL be ignored; only flushDE aborts.
REQ-038 iter SHALL hold when not in BUSY and SHALL never wrap past N-1.

Reset
REQ-039 reset=1 SHALL force state IDLE, iter=0 and special=0 on the next edge, with priority over flushDE and req.
REQ-040 reset asserted mid-BUSY SHALL abandon the operation with no result_valid.
REQ-041 Out of reset, every output SHALL be 0 while req=0: load, step_en, iter, sel_div, special, result_valid, doing.

Verification
REQ-042 MUL req at cycle 0, a=3, b=5 -> load at 0, step_en cycles 1-3, result_valid at cycle 4, doing=1 cycles 0-3.
REQ-043 DIVW, b=0x0000_0001_0000_0000 -> special=1, result_valid at cycle 1, step_en never 1.
REQ-044 DIV, a=0x8000_0000_0000_0000, b=all-ones -> special=2 at cycle 1; DIVU with the same operands -> 64 BUSY cycles, result_valid at cycle 65.
REQ-045 DIV accepted, flushDE at BUSY iter 10 -> IDLE next cycle, no result_valid, a new req is then accepted normally.
REQ-046 REMW completes with stalllDE=1 for 3 cycles -> result_valid held 4 cycles, doing=0, exactly one load; reset at iter 20 of a DIV -> all outputs 0 next cycle.
